demux_stream_dispatch: RTL and testbench

Registered 1-to-4 stream dispatcher that sits directly upstream of the 1-to-4 demux stage and turns its select/data pair into a flow-controlled stream. Each word accepted on a valid/ready input is routed to exactly one of four output channels. The word is held in a single output register until that channel's consumer takes it. A per-channel delivered-word counter supports bench checking and debug.

---
 rtl/demux_stream_dispatch_if.sv | 24 ++
 rtl/demux_stream_dispatch.sv | 93 +++++++++
 tb/tb_demux_stream_dispatch.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/demux_stream_dispatch_if.sv
// Stream bundle between the upstream producer, the dispatcher and the four
// channel consumers. The slave modport is the dispatcher's view.
interface demux_stream_dispatch_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_sel;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/demux_stream_dispatch.sv
// Registered 1-to-4 stream dispatcher with per-channel delivered counters.
// Define DEMUX_RR_EN to route by an internal round-robin pointer instead of in_sel.
module demux_stream_dispatch #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    demux_stream_dispatch_if.slave bus,
    output logic [4*CNT_W-1:0]     cnt_flat
);
    typedef enum logic {EMPTY, FULL} state_t;

    state_t                      state_q, state_d;
    logic [WIDTH-1:0]            out_data_q, out_data_d;
    logic [1:0]                  out_sel_q, out_sel_d;
    logic [3:0]                  out_valid_q, out_valid_d;
    logic [3:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]                  dest;
    logic                        accept;
    logic                        deliver;

`ifdef DEMUX_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [1:0] unused_in_sel;

    assign unused_in_sel = bus.in_sel;
    assign dest          = rr_ptr_q;
`else
    assign dest = bus.in_sel;
`endif

    // in_ready depends only on state and out_ready, never on in_valid.
    assign deliver      = (state_q == FULL) && bus.out_ready[out_sel_q];
    assign bus.in_ready = (state_q == EMPTY) || bus.out_ready[out_sel_q];
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        out_sel_d  = out_sel_q;
        cnt_d      = cnt_q;
        if (accept) begin
            state_d    = FULL;
            out_data_d = bus.in_data;
            out_sel_d  = dest;
        end else if (deliver) begin
            state_d = EMPTY;
        end
        if (deliver) begin
            cnt_d[out_sel_q] = cnt_q[out_sel_q] + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        out_valid_d = (state_d == FULL) ? (4'b0001 << out_sel_d) : 4'b0000;
    end

`ifdef DEMUX_RR_EN
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign cnt_flat      = cnt_q;
endmodule

// File: tb/tb_demux_stream_dispatch.sv
// Directed self-checking bench for demux_stream_dispatch; covers the explicit
// routing build by default and the round-robin build when DEMUX_RR_EN is defined.
module tb_demux_stream_dispatch;
    localparam int WIDTH = 8;
    localparam int CNT_W = 8;

    logic               clk;
    logic               rst;
    logic [4*CNT_W-1:0] cnt_flat;
    int                 n_checks;
    int                 n_errors;

    demux_stream_dispatch_if #(.WIDTH(WIDTH)) bus ();

    demux_stream_dispatch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .cnt_flat (cnt_flat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cnt(input int k);
        return 32'(cnt_flat[k*CNT_W +: CNT_W]);
    endfunction

    // Advance one edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sel   = s;
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_cnts(input string tag, input int c0, input int c1, input int c2, input int c3);
        check({tag, "_cnt0"}, cnt(0), 32'(c0));
        check({tag, "_cnt1"}, cnt(1), 32'(c1));
        check({tag, "_cnt2"}, cnt(2), 32'(c2));
        check({tag, "_cnt3"}, cnt(3), 32'(c3));
    endtask

    initial begin
        logic [7:0] words [4];
        logic [1:0] rr_exp [6];
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sel    = '0;
        bus.out_ready = 4'b0000;
        words         = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        rr_exp        = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        do_reset();
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data", 32'(bus.out_data), 32'h0);
        check("rst_out_sel", 32'(bus.out_sel), 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        check_cnts("rst", 0, 0, 0, 0);

`ifndef DEMUX_RR_EN
        // Explicit routing at full rate.
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            send(words[i], 2'(i));
            check($sformatf("route_in_ready_%0d", i), 32'(bus.in_ready), 32'h1);
            step();
            check($sformatf("route_valid_%0d", i), 32'(bus.out_valid), 32'(4'b0001 << i));
            check($sformatf("route_data_%0d", i), 32'(bus.out_data), 32'(words[i]));
        end
        bus.in_valid = 1'b0;
        step();
        check("route_drained", 32'(bus.out_valid), 32'h0);
        check_cnts("route", 1, 1, 1, 1);

        // Backpressure on channel 2 with a second word waiting for channel 0.
        bus.out_ready = 4'b1011;
        send(8'h55, 2'd2);
        step();
        check("bp_valid", 32'(bus.out_valid), 32'b0100);
        check("bp_in_ready", 32'(bus.in_ready), 32'h0);
        send(8'h66, 2'd0);
        step();
        check("bp_hold_valid", 32'(bus.out_valid), 32'b0100);
        check("bp_hold_data", 32'(bus.out_data), 32'h55);
        check("bp_hold_sel", 32'(bus.out_sel), 32'h2);
        check("bp_cnt2_stalled", cnt(2), 32'h1);
        bus.out_ready = 4'b1111;
        #1;
        check("bp_release_ready", 32'(bus.in_ready), 32'h1);
        step();
        bus.in_valid = 1'b0;
        check("bp_next_valid", 32'(bus.out_valid), 32'b0001);
        check("bp_next_data", 32'(bus.out_data), 32'h66);
        check_cnts("bp_mid", 1, 1, 2, 1);
        step();
        check("bp_drained", 32'(bus.out_valid), 32'h0);
        check_cnts("bp_end", 2, 1, 2, 1);

        // 257 deliveries to channel 1 wrap its 8-bit counter to 1.
        do_reset();
        bus.out_ready = 4'b1111;
        send(8'h11, 2'd1);
        for (int i = 0; i < 257; i++) step();
        bus.in_valid = 1'b0;
        step();
        check_cnts("wrap", 0, 1, 0, 0);

        // A held word is discarded by reset, never delivered or counted.
        do_reset();
        bus.out_ready = 4'b0000;
        send(8'h77, 2'd3);
        step();
        bus.in_valid = 1'b0;
        check("mr_held_valid", 32'(bus.out_valid), 32'b1000);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr_valid", 32'(bus.out_valid), 32'h0);
        check("mr_data", 32'(bus.out_data), 32'h0);
        bus.out_ready = 4'b1111;
        step();
        step();
        check("mr_after_valid", 32'(bus.out_valid), 32'h0);
        check_cnts("mr", 0, 0, 0, 0);
`else
        // Round robin ignores in_sel and cycles 0,1,2,3,0,1.
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            send(8'hB0 + 8'(i), 2'd3);
            step();
            check($sformatf("rr_sel_%0d", i), 32'(bus.out_sel), 32'(rr_exp[i]));
            check($sformatf("rr_valid_%0d", i), 32'(bus.out_valid), 32'(4'b0001 << rr_exp[i]));
            check($sformatf("rr_data_%0d", i), 32'(bus.out_data), 32'(8'hB0 + 8'(i)));
        end
        bus.in_valid = 1'b0;
        step();
        step();
        check("rr_idle_valid", 32'(bus.out_valid), 32'h0);
        check_cnts("rr", 2, 2, 1, 1);

        // Reset discards the held word and rewinds the pointer to 0.
        bus.out_ready = 4'b0000;
        send(8'h77, 2'd3);
        step();
        bus.in_valid = 1'b0;
        check("rr_mr_held_sel", 32'(bus.out_sel), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rr_mr_valid", 32'(bus.out_valid), 32'h0);
        check_cnts("rr_mr", 0, 0, 0, 0);
        bus.out_ready = 4'b1111;
        send(8'h88, 2'd3);
        step();
        bus.in_valid = 1'b0;
        check("rr_mr_ptr0", 32'(bus.out_valid), 32'b0001);
        step();
        check_cnts("rr_mr_end", 1, 0, 0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
